// File: rtl/vna_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vna_avg_pkg
// Description : Shared types, constants and the round/saturate helper for the
//               multi-channel VNA I/Q averager.
// Revision    : 1.0 - initial release
// ============================================================================
package vna_avg_pkg;

    localparam int LOG2_AVG_W = 4;

    // Averager control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Scaled result plus a flag telling whether it had to be clipped
    typedef struct packed {
        logic              sat;
        logic signed [63:0] val;
    } round_sat_t;

    // Divide by 2^k with round-half-up, then clip to a signed out_w-bit range.
    // The arithmetic shift floors, so adding half an LSB first rounds ties
    // toward +inf for both signs.
    function automatic round_sat_t round_sat(
        input logic signed [63:0]          sum,
        input logic [LOG2_AVG_W-1:0]       k,
        input int                          out_w
    );
        round_sat_t         res;
        logic signed [63:0] bias;
        logic signed [63:0] shifted;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        res     = '0;
        bias    = (k == '0) ? 64'sd0 : (64'sd1 <<< (k - 1'b1));
        shifted = (sum + bias) >>> k;
        hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (out_w - 1));
        if (shifted > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (shifted < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end else begin
            res.sat = 1'b0;
            res.val = shifted;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vna_avg_chan.sv
`default_nettype none
// ============================================================================
// Module      : vna_avg_chan
// Description : One I/Q channel of the averager: two accumulators and the
//               round/saturate output register stage.
// Revision    : 1.0 - initial release
// ============================================================================
module vna_avg_chan
    import vna_avg_pkg::*;
#(
    parameter int IN_WIDTH  = 22,
    parameter int OUT_WIDTH = 24,
    parameter int ACC_WIDTH = 34
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        add,
    input  logic                        load_out,
    input  logic [LOG2_AVG_W-1:0]       k,
    input  logic signed [IN_WIDTH-1:0]  in_i,
    input  logic signed [IN_WIDTH-1:0]  in_q,
    output logic signed [OUT_WIDTH-1:0] out_i,
    output logic signed [OUT_WIDTH-1:0] out_q,
    output logic                        out_sat
);

    logic signed [ACC_WIDTH-1:0] r_acc_i;
    logic signed [ACC_WIDTH-1:0] r_acc_q;
    logic signed [OUT_WIDTH-1:0] r_out_i;
    logic signed [OUT_WIDTH-1:0] r_out_q;
    logic                        r_out_sat;

    logic signed [ACC_WIDTH-1:0] w_ext_i;
    logic signed [ACC_WIDTH-1:0] w_ext_q;
    round_sat_t                  w_rs_i;
    round_sat_t                  w_rs_q;

    assign w_ext_i = ACC_WIDTH'(in_i);
    assign w_ext_q = ACC_WIDTH'(in_q);

    // Scaled view of the running sums, captured only while rounding
    always_comb begin
        w_rs_i = round_sat(64'(r_acc_i), k, OUT_WIDTH);
        w_rs_q = round_sat(64'(r_acc_q), k, OUT_WIDTH);
    end

    // Accumulate sign-extended samples; clear wins over add
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (clear) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (add) begin
            r_acc_i <= r_acc_i + w_ext_i;
            r_acc_q <= r_acc_q + w_ext_q;
        end
    end

    // Output registers hold the last result until the next rounding step
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_i   <= '0;
            r_out_q   <= '0;
            r_out_sat <= 1'b0;
        end else if (load_out) begin
            r_out_i   <= w_rs_i.val[OUT_WIDTH-1:0];
            r_out_q   <= w_rs_q.val[OUT_WIDTH-1:0];
            r_out_sat <= w_rs_i.sat | w_rs_q.sat;
        end
    end

    assign out_i   = r_out_i;
    assign out_q   = r_out_q;
    assign out_sat = r_out_sat;

endmodule
`default_nettype wire

// File: rtl/vna_avg_multi.sv
`default_nettype none
// ============================================================================
// Module      : vna_avg_multi
// Description : Multi-channel coherent I/Q averager with runtime length,
//               round-half-up, saturation and valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module vna_avg_multi
    import vna_avg_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int IN_WIDTH     = 22,
    parameter int OUT_WIDTH    = 24,
    parameter int MAX_LOG2_AVG = 12,
    parameter int ACC_WIDTH    = IN_WIDTH + MAX_LOG2_AVG
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          vna,
    input  logic [LOG2_AVG_W-1:0]         log2_avg,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [CHANNELS*IN_WIDTH-1:0]  in_I,
    input  logic [CHANNELS*IN_WIDTH-1:0]  in_Q,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNELS*OUT_WIDTH-1:0] out_I,
    output logic [CHANNELS*OUT_WIDTH-1:0] out_Q,
    output logic [CHANNELS-1:0]           out_sat,
    output logic                          busy
);

    // One extra bit so the counter can represent 2^MAX_LOG2_AVG
    localparam int CNT_W = MAX_LOG2_AVG + 1;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [LOG2_AVG_W-1:0]   r_k;
    logic                    r_start_pending;

    logic                    w_clear;
    logic                    w_add;
    logic                    w_load;
    logic                    w_pend_next;
    logic                    w_last;
    logic [LOG2_AVG_W-1:0]   w_k_req;

    assign w_k_req = (int'(log2_avg) > MAX_LOG2_AVG) ? LOG2_AVG_W'(MAX_LOG2_AVG) : log2_avg;
    assign w_last  = ((r_cnt + CNT_W'(1)) == (CNT_W'(1) << r_k));

    // Next-state and per-cycle datapath controls; clear also re-latches k
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_add        = 1'b0;
        w_load       = 1'b0;
        w_pend_next  = r_start_pending;
        if (!vna) begin
            w_next_state = IDLE;
            w_pend_next  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_next_state = ACCUM;
                        w_clear      = 1'b1;
                    end
                end
                ACCUM: begin
                    if (start) begin
                        // restart: the sample on this cycle is dropped
                        w_clear = 1'b1;
                    end else if (in_valid) begin
                        w_add = 1'b1;
                        if (w_last) begin
                            w_next_state = ROUND;
                        end
                    end
                end
                ROUND: begin
                    w_load       = 1'b1;
                    w_next_state = HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        if (r_start_pending || start) begin
                            w_next_state = ACCUM;
                            w_clear      = 1'b1;
                            w_pend_next  = 1'b0;
                        end else begin
                            w_next_state = IDLE;
                        end
                    end else if (start) begin
                        w_pend_next = 1'b1;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // State, sample counter, latched length and deferred start request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_k             <= '0;
            r_start_pending <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_start_pending <= w_pend_next;
            if (w_clear) begin
                r_cnt <= '0;
                r_k   <= w_k_req;
            end else if (w_add) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        vna_avg_chan #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_chan (
            .clock    (clock),
            .reset_n  (reset_n),
            .clear    (w_clear),
            .add      (w_add),
            .load_out (w_load),
            .k        (r_k),
            .in_i     (in_I[g*IN_WIDTH +: IN_WIDTH]),
            .in_q     (in_Q[g*IN_WIDTH +: IN_WIDTH]),
            .out_i    (out_I[g*OUT_WIDTH +: OUT_WIDTH]),
            .out_q    (out_Q[g*OUT_WIDTH +: OUT_WIDTH]),
            .out_sat  (out_sat[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_vna_avg_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vna_avg_multi
// Description : Self-checking bench for vna_avg_multi (2 channels, 22-bit in,
//               16-bit out): vector table plus handshake/restart/reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vna_avg_multi;

    localparam int CH   = 2;
    localparam int IW   = 22;
    localparam int OW   = 16;
    localparam int MAXL = 12;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                vna;
    logic [3:0]          log2_avg;
    logic                start;
    logic                in_valid;
    logic [CH*IW-1:0]    in_I;
    logic [CH*IW-1:0]    in_Q;
    logic                out_valid;
    logic                out_ready;
    logic [CH*OW-1:0]    out_I;
    logic [CH*OW-1:0]    out_Q;
    logic [CH-1:0]       out_sat;
    logic                busy;

    int checks = 0;
    int errors = 0;

    typedef logic [3:0][31:0] pat_t;

    typedef struct packed {
        logic [3:0]  lg;
        pat_t        i0;
        pat_t        q0;
        logic [31:0] i1;
        logic [31:0] q1;
        logic [31:0] ei0;
        logic [31:0] eq0;
        logic [31:0] ei1;
        logic [31:0] eq1;
        logic [1:0]  esat;
    } vec_t;

    vec_t vecs [7];

    // channel 0 cycles through a 4-entry pattern, channel 1 is constant
    pat_t cur_i0;
    pat_t cur_q0;
    int   cur_i1;
    int   cur_q1;

    vna_avg_multi #(
        .CHANNELS     (CH),
        .IN_WIDTH     (IW),
        .OUT_WIDTH    (OW),
        .MAX_LOG2_AVG (MAXL)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .vna       (vna),
        .log2_avg  (log2_avg),
        .start     (start),
        .in_valid  (in_valid),
        .in_I      (in_I),
        .in_Q      (in_Q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_I     (out_I),
        .out_Q     (out_Q),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #4 clock = ~clock;

    function automatic pat_t p4(input int a, input int b, input int c, input int d);
        pat_t r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        r[3] = d;
        return r;
    endfunction

    function automatic int oi(input int ch);
        return int'($signed(out_I[ch*OW +: OW]));
    endfunction

    function automatic int oq(input int ch);
        return int'($signed(out_Q[ch*OW +: OW]));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input int ei0, input int eq0,
                                input int ei1, input int eq1, input int esat);
        check({tag, ".i0"},  oi(0), ei0);
        check({tag, ".q0"},  oq(0), eq0);
        check({tag, ".i1"},  oi(1), ei1);
        check({tag, ".q1"},  oq(1), eq1);
        check({tag, ".sat"}, int'(out_sat), esat);
    endtask

    task automatic set_pat(input pat_t i0, input pat_t q0, input int i1, input int q1);
        cur_i0 = i0;
        cur_q0 = q0;
        cur_i1 = i1;
        cur_q1 = q1;
    endtask

    task automatic drive_sample(input int j);
        in_I     = {IW'(cur_i1), IW'(cur_i0[j % 4])};
        in_Q     = {IW'(cur_q1), IW'(cur_q0[j % 4])};
        in_valid = 1'b1;
    endtask

    // Present n valid samples on consecutive cycles without watching outputs
    task automatic feed(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clock);
            start     = 1'b0;
            out_ready = 1'b0;
            drive_sample(j);
        end
    endtask

    // Called right after the edge that accepts a start; feeds n samples and
    // returns the cycle number (relative to that edge) where out_valid is seen,
    // or -1 if it never shows up.
    task automatic run_samples(input int n, output int cyc);
        int j;
        bit got;
        j   = 0;
        got = 1'b0;
        cyc = 0;
        while (cyc < n + 50 && !got) begin
            @(negedge clock);
            cyc++;
            start     = 1'b0;
            out_ready = 1'b0;
            if (cyc == 1) log2_avg = 4'd1;   // later changes must not matter
            if (out_valid) begin
                got = 1'b1;
            end else if (j < n) begin
                drive_sample(j);
                j++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (!got) cyc = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int n;
        int bad;

        // lg, i0 pattern, q0 pattern, i1, q1, expected i0, q0, i1, q1, sat
        vecs[0] = '{lg: 4'd9,  i0: p4(1000, 1000, 1000, 1000), q0: p4(-1000, -1000, -1000, -1000),
                    i1: 500, q1: -3, ei0: 1000, eq0: -1000, ei1: 500, eq1: -3, esat: 2'b00};
        vecs[1] = '{lg: 4'd2,  i0: p4(1, 2, 2, 2), q0: p4(-1, -2, -2, -2),
                    i1: 7, q1: 0, ei0: 2, eq0: -2, ei1: 7, eq1: 0, esat: 2'b00};
        vecs[2] = '{lg: 4'd0,  i0: p4(2097151, 0, 0, 0), q0: p4(-2097152, 0, 0, 0),
                    i1: 100, q1: -100, ei0: 32767, eq0: -32768, ei1: 100, eq1: -100, esat: 2'b01};
        vecs[3] = '{lg: 4'd1,  i0: p4(3, 0, 0, 0), q0: p4(-3, 0, 0, 0),
                    i1: 40000, q1: -40000, ei0: 2, eq0: -1, ei1: 32767, eq1: -32768, esat: 2'b10};
        vecs[4] = '{lg: 4'd3,  i0: p4(5, 6, 7, 8), q0: p4(-5, -6, -7, -8),
                    i1: 0, q1: 1, ei0: 7, eq0: -6, ei1: 0, eq1: 1, esat: 2'b00};
        vecs[5] = '{lg: 4'd15, i0: p4(1, 1, 1, 2), q0: p4(0, 0, 0, -1),
                    i1: -1, q1: 32767, ei0: 1, eq0: 0, ei1: -1, eq1: 32767, esat: 2'b00};
        vecs[6] = '{lg: 4'd4,  i0: p4(32767, 32768, 32767, 32768), q0: p4(-32768, -32768, -32768, -32768),
                    i1: -32769, q1: 0, ei0: 32767, eq0: -32768, ei1: -32768, eq1: 0, esat: 2'b11};

        reset_n   = 1'b0;
        vna       = 1'b1;
        log2_avg  = 4'd0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_I      = '0;
        in_Q      = '0;
        out_ready = 1'b0;
        cur_i0    = '0;
        cur_q0    = '0;
        cur_i1    = 0;
        cur_q1    = 0;

        repeat (3) @(negedge clock);
        check("reset.out_valid", int'(out_valid), 0);
        check("reset.busy",      int'(busy), 0);
        check_result("reset", 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // ---------------- vector table ----------------
        for (int v = 0; v < 7; v++) begin
            n = 1 << ((int'(vecs[v].lg) > MAXL) ? MAXL : int'(vecs[v].lg));
            set_pat(vecs[v].i0, vecs[v].q0, int'($signed(vecs[v].i1)), int'($signed(vecs[v].q1)));
            log2_avg = vecs[v].lg;
            start    = 1'b1;
            run_samples(n, cyc);
            check($sformatf("v%0d.latency", v), cyc, n + 2);
            check($sformatf("v%0d.busy", v), int'(busy), 1);
            check_result($sformatf("v%0d", v), int'($signed(vecs[v].ei0)), int'($signed(vecs[v].eq0)),
                         int'($signed(vecs[v].ei1)), int'($signed(vecs[v].eq1)), int'(vecs[v].esat));
            out_ready = 1'b1;
            @(negedge clock);
            out_ready = 1'b0;
            check($sformatf("v%0d.valid_after_hs", v), int'(out_valid), 0);
            check($sformatf("v%0d.idle_after_hs", v), int'(busy), 0);
        end

        // ---------------- back-pressure with start pending ----------------
        set_pat(p4(10, 10, 10, 10), p4(-10, -10, -10, -10), 20, -20);
        log2_avg = 4'd2;
        start    = 1'b1;
        run_samples(4, cyc);
        check("bp.latency", cyc, 6);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            start    = (c == 5);
            in_I     = {IW'(12345), IW'(-999)};
            in_Q     = {IW'(-4321), IW'(777)};
            in_valid = 1'b1;
            if (!out_valid || oi(0) != 10 || oq(0) != -10 || oi(1) != 20 || oq(1) != -20 || out_sat != 2'b00)
                bad++;
        end
        check("bp.hold_stable_bad_cycles", bad, 0);
        set_pat(p4(30, 30, 30, 30), p4(-30, -30, -30, -30), -5, 5);
        log2_avg  = 4'd2;
        out_ready = 1'b1;
        run_samples(4, cyc);
        check("bp.pending_latency", cyc, 6);
        check_result("bp.second", 30, -30, -5, 5, 0);

        // start together with the handshake: straight back into ACCUM
        set_pat(p4(-100, -100, -100, -100), p4(100, 100, 100, 100), 3, -3);
        log2_avg  = 4'd2;
        out_ready = 1'b1;
        start     = 1'b1;
        run_samples(4, cyc);
        check("b2b.latency", cyc, 6);
        check_result("b2b", -100, 100, 3, -3, 0);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("b2b.idle", int'(busy), 0);

        // ---------------- restart mid-accumulation ----------------
        set_pat(p4(7000, 7000, 7000, 7000), p4(-7000, -7000, -7000, -7000), 7000, -7000);
        log2_avg = 4'd9;
        start    = 1'b1;
        feed(100);
        @(negedge clock);
        start    = 1'b1;
        in_I     = {IW'(30000), IW'(30000)};
        in_Q     = {IW'(30000), IW'(30000)};
        in_valid = 1'b1;
        set_pat(p4(-50, -50, -50, -50), p4(50, 50, 50, 50), 123, -7);
        run_samples(512, cyc);
        check("restart.latency", cyc, 514);
        check_result("restart", -50, 50, 123, -7, 0);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;

        // ---------------- vna dropped mid-accumulation ----------------
        set_pat(p4(9, 9, 9, 9), p4(9, 9, 9, 9), 9, 9);
        log2_avg = 4'd2;
        start    = 1'b1;
        feed(2);
        @(negedge clock);
        vna = 1'b0;
        @(negedge clock);
        vna = 1'b1;
        check("vna.busy", int'(busy), 0);
        check("vna.out_valid", int'(out_valid), 0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            drive_sample(c);
            @(negedge clock);
            if (out_valid || busy) bad++;
        end
        in_valid = 1'b0;
        check("vna.stays_idle_bad_cycles", bad, 0);
        check("vna.out_i0_kept", oi(0), -50);

        // ---------------- reset while holding a result ----------------
        set_pat(p4(5, 5, 5, 5), p4(-5, -5, -5, -5), 6, -6);
        log2_avg = 4'd0;
        start    = 1'b1;
        run_samples(1, cyc);
        check("rst.latency", cyc, 3);
        check_result("rst.pre", 5, -5, 6, -6, 0);
        reset_n = 1'b0;
        #1;
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.busy", int'(busy), 0);
        check_result("rst.post", 0, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vna_avg_multi.md
# vna_avg_multi

Parametrised multi-channel coherent I/Q averager for VNA mode. It accumulates 2^k consecutive valid complex samples per channel, divides by 2^k with round-half-up, saturates to the output width, and presents the result through a valid/ready handshake. It sits after the CORDIC outputs of one or more receivers. It supersedes the fixed 512-sample, single-channel, truncating averager with runtime-selectable length, rounding, saturation, overflow reporting and back-pressure.

## Interface
Parameters:
- CHANNELS, 2: number of independent I/Q channels, 1..8.
- IN_WIDTH, 22: signed width of each input I or Q sample.
- OUT_WIDTH, 24: signed width of each output I or Q sample.
- MAX_LOG2_AVG, 12: largest supported log2 of the average length.
- ACC_WIDTH, IN_WIDTH+MAX_LOG2_AVG: derived accumulator width; never overridden.

Ports:
- clock  in  1  122.88 MHz system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vna  in  1  enable; low forces IDLE.
- log2_avg  in  4  requested log2 of average length; sampled on accepted start.
- start  in  1  single-cycle request to begin a new average.
- in_valid  in  1  the in_I/in_Q samples are valid this cycle.
- in_I  in  CHANNELS*IN_WIDTH  packed signed I samples; channel 0 in the LSBs.
- in_Q  in  CHANNELS*IN_WIDTH  packed signed Q samples; channel 0 in the LSBs.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_I  out  CHANNELS*OUT_WIDTH  packed averaged I.
- out_Q  out  CHANNELS*OUT_WIDTH  packed averaged Q.
- out_sat  out  CHANNELS  per-channel flag: I or Q was clipped in this result.
- busy  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: waits for start.
  - ACCUM: adds samples.
  - ROUND: computes the scaled output.
  - HOLD: presents the result.
- IDLE→ACCUM on start && vna. On entry:
  - sums and sample counter clear;
  - k = min(log2_avg, MAX_LOG2_AVG) is latched.
- ACCUM:
  - each cycle with in_valid, every channel adds its sign-extended I/Q to its ACC_WIDTH sum, and the counter increments;
  - when the counter reaches 2^k, go to ROUND.
- start in ACCUM restarts the average: sums clear, the counter clears, k re-latches, and the sample on that cycle is discarded.
- ROUND: per channel, out = sat_OUT_WIDTH((sum + (k>0 ? 2^(k-1) : 0)) >>> k).
  - The shift is arithmetic, so rounding is half-up toward +inf.
  - Saturation clips to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and sets that channel's out_sat bit.
  - Outputs register at the end of ROUND. Next state is HOLD.
- HOLD:
  - out_valid = 1; out_I, out_Q and out_sat are stable.
  - The handshake completes on out_valid && out_ready.
  - start while in HOLD sets start_pending; the held result is never overwritten.
  - On completion: go to ACCUM if start_pending or start is high that cycle (clearing start_pending and latching k), otherwise go to IDLE.
- in_valid is ignored in IDLE, ROUND and HOLD.
- k = 0 is a pass-through of one sample, still rounded and saturated.
- log2_avg > MAX_LOG2_AVG clamps to MAX_LOG2_AVG. Changes to log2_avg outside an accepted start have no effect.
- vna low in any state:
  - next state is IDLE;
  - out_valid clears and start_pending clears;
  - out_I, out_Q and out_sat keep their last values.

## Timing
- Reset values: every output 0; state IDLE; sums, counter, k and start_pending 0.
- An accepted start in cycle N means the first sample counted is one with in_valid in cycle N+1 or later.
- If the final (2^k-th) sample is presented in cycle M, then ROUND is cycle M+1 and out_valid is high from cycle M+2.
- out_valid falls on the cycle after the handshake edge.
- Back-to-back averaging: with start held during the handshake cycle, ACCUM begins the next cycle. There is a one-cycle gap during which samples are not counted.
- No combinational path from in_* or out_ready to any output.
- Asserting reset_n low mid-operation returns the block to the reset values immediately; partial sums are lost.

## Structure
- Package vna_avg_pkg holds:
  - the state enum (IDLE, ACCUM, ROUND, HOLD);
  - LOG2_AVG_W = 4;
  - a sat/round function parametrised by width.
- Sub-module vna_avg_chan, one instance per channel via generate, contains:
  - the I and Q accumulators;
  - the round/saturate stage and output registers.
  - It is driven by clear/add/latch controls from the top.
- The top holds the FSM, the counter, k and start_pending.

## Test plan
- CHANNELS=2, log2_avg=9, constant I=+1000, Q=-1000 every cycle → out_I=1000, out_Q=-1000, out_valid 514 cycles after start, out_sat=0.
- log2_avg=2, I samples 1,2,2,2 → sum 7, (7+2)>>>2 = 2. Samples -1,-2,-2,-2 → (-7+2)>>>2 = -2.
- IN_WIDTH=22, OUT_WIDTH=16, constant I=+2^21-1, k=0 → out_I=32767, out_sat bit set. Constant I=-2^21 → out_I=-32768.
- out_ready held low 100 cycles with start pulsed in HOLD → result stable throughout. After out_ready, ACCUM starts next cycle and the second result matches the new data.
- start mid-ACCUM after 100 of 512 samples → output equals the average of the 512 samples after restart only.
- vna dropped mid-ACCUM → IDLE next cycle and out_valid stays 0. reset_n pulsed low in HOLD → all outputs 0 and busy=0.
